cpu_ifetch_prefetch: RTL and testbench

Parametrised, streaming instruction fetch unit for the RAPID core; successor to the single-outstanding FSM fetch stage. It keeps several icache reads in flight and buffers returned instructions in a FIFO. The decode stage therefore receives one instruction per cycle once the stream is primed, instead of NOPs between fetches. It also supports a pipeline-driven PC redirect, which flushes the buffer and discards stale in-flight responses.

---
 rtl/cpu_ifetch_prefetch.sv | 199 +++++++++++++++++++
 tb/tb_cpu_ifetch_prefetch.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ifetch_prefetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cpu_ifetch_prefetch
//  Description : Streaming instruction fetch unit. Keeps up to MAX_OUTSTANDING
//                icache reads in flight and buffers the returned words in a
//                FIFO_DEPTH-entry {pc, instr} FIFO, so decode sees one
//                instruction per cycle once the stream is primed. A pipeline
//                redirect flushes the buffer and discards stale responses.
//
//  Ports       : i_clk, i_reset         clock / synchronous active-high reset
//                i_redirect, i_redirect_pc  load new fetch PC (bits [1:0] ignored)
//                i_pipeline_ready       consumer takes the head this cycle
//                o_valid, o_pc, o_instruction  FIFO head (0 / NOOP when empty)
//                o_req_valid, o_req_addr, i_req_ready  icache request channel
//                i_rsp_valid, i_rsp_data               icache in-order responses
//
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_ifetch_prefetch #(
    parameter int              XLEN             = 32,
    parameter int              FIFO_DEPTH       = 4,
    parameter int              MAX_OUTSTANDING  = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR     = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOOP_INSTRUCTION = 32'h0000_0013
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_pipeline_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instruction,
    output logic            o_req_valid,
    output logic [XLEN-1:0] o_req_addr,
    input  logic            i_req_ready,
    input  logic            i_rsp_valid,
    input  logic [XLEN-1:0] i_rsp_data
);

    // ------------------------------------------------------------------------
    // Widths and typed constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_OUT_W = $clog2(MAX_OUTSTANDING + 1);
    // Credit sum is inflight + count, each bounded by FIFO_DEPTH.
    localparam int c_CRD_W = $clog2(2 * FIFO_DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CRD_W-1:0] c_CRD_LIMIT = c_CRD_W'(FIFO_DEPTH);
    localparam logic [c_OUT_W-1:0] c_MAX_OUT   = c_OUT_W'(MAX_OUTSTANDING);
    localparam logic [XLEN-1:0]    c_PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0]    c_ALIGN_MSK = ~(XLEN'(3));

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [XLEN-1:0]    r_fpc;          // next fetch address
    logic [XLEN-1:0]    r_rpc;          // PC tagged onto the next kept response
    logic [c_OUT_W-1:0] r_inflight;     // accepted, not yet answered requests
    logic [c_OUT_W-1:0] r_drop_cnt;     // how many of those are stale
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;

    logic [XLEN-1:0]    r_fifo_pc    [FIFO_DEPTH];
    logic [XLEN-1:0]    r_fifo_instr [FIFO_DEPTH];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic               w_valid;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_rsp_drop;
    logic               w_push;
    logic               w_pop;
    logic [c_CRD_W-1:0] w_credit_used;
    logic [c_OUT_W-1:0] w_inflight_next;
    logic [XLEN-1:0]    w_redirect_pc;

    assign w_redirect_pc = i_redirect_pc & c_ALIGN_MSK;
    assign w_valid       = (r_count != '0);

    // Every live (non-dropped) in-flight request already owns a FIFO slot,
    // so a response can always be pushed without backpressuring the icache.
    assign w_credit_used = c_CRD_W'(r_inflight) - c_CRD_W'(r_drop_cnt)
                         + c_CRD_W'(r_count);

    // Held low while reset is asserted so nothing is issued before the
    // reset state has been loaded; the first request follows reset release.
    assign w_req_valid = !i_reset && !i_redirect
                       && (r_inflight < c_MAX_OUT)
                       && (w_credit_used < c_CRD_LIMIT);

    assign w_req_fire = w_req_valid && i_req_ready;
    assign w_rsp_drop = i_rsp_valid && (r_drop_cnt != '0);
    assign w_push     = !i_redirect && i_rsp_valid && (r_drop_cnt == '0);
    assign w_pop      = w_valid && i_pipeline_ready && !i_redirect;

    // No request is issued during a redirect, so the same next value also
    // gives inflight - rsp_valid for the redirect case.
    always_comb begin
        w_inflight_next = r_inflight;
        if (w_req_fire && !i_rsp_valid) begin
            w_inflight_next = r_inflight + c_OUT_W'(1);
        end else if (!w_req_fire && i_rsp_valid) begin
            w_inflight_next = r_inflight - c_OUT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fpc      <= RESET_VECTOR;
            r_rpc      <= RESET_VECTOR;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (i_redirect) begin
            // Everything still outstanding after this cycle is stale,
            // including nothing that arrives now (it is simply not pushed).
            r_fpc      <= w_redirect_pc;
            r_rpc      <= w_redirect_pc;
            r_inflight <= w_inflight_next;
            r_drop_cnt <= w_inflight_next;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= w_inflight_next;

            if (w_req_fire) begin
                r_fpc <= r_fpc + c_PC_STEP;
            end

            if (w_rsp_drop) begin
                r_drop_cnt <= r_drop_cnt - c_OUT_W'(1);
            end

            if (w_push) begin
                r_rpc    <= r_rpc + c_PC_STEP;
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage (data only, no reset needed: validity lives in r_count)
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_rpc;
            r_fifo_instr[r_wr_ptr] <= i_rsp_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_valid       = w_valid;
    assign o_pc          = w_valid ? r_fifo_pc[r_rd_ptr]    : '0;
    assign o_instruction = w_valid ? r_fifo_instr[r_rd_ptr] : NOOP_INSTRUCTION;
    assign o_req_valid   = w_req_valid;
    assign o_req_addr    = r_fpc;

    // ------------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------------
    a_no_push_when_full : assert property (@(posedge i_clk) disable iff (i_reset)
        !(w_push && !w_pop && (r_count == c_FIFO_FULL)));

    a_inflight_bound : assert property (@(posedge i_clk) disable iff (i_reset)
        (r_inflight <= c_MAX_OUT));

    a_drop_le_inflight : assert property (@(posedge i_clk) disable iff (i_reset)
        (r_drop_cnt <= r_inflight));

    a_rsp_has_request : assert property (@(posedge i_clk) disable iff (i_reset)
        (i_rsp_valid |-> (r_inflight != '0)));

endmodule
`default_nettype wire

// File: tb/tb_cpu_ifetch_prefetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_ifetch_prefetch
//  Description : Self-checking bench for cpu_ifetch_prefetch. An in-order
//                icache model with programmable latency feeds the DUT; a
//                stream-level reference (expected next consumed PC, expected
//                next request address) checks every handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_ifetch_prefetch;

    localparam int          XLEN         = 32;
    localparam int          FIFO_DEPTH   = 4;
    localparam int          MAX_OUT      = 2;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] NOOP         = 32'h0000_0013;

    logic        i_clk;
    logic        i_reset;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_pipeline_ready;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_instruction;
    logic        o_req_valid;
    logic [31:0] o_req_addr;
    logic        i_req_ready;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;

    cpu_ifetch_prefetch #(
        .XLEN             (XLEN),
        .FIFO_DEPTH       (FIFO_DEPTH),
        .MAX_OUTSTANDING  (MAX_OUT),
        .RESET_VECTOR     (RESET_VECTOR),
        .NOOP_INSTRUCTION (NOOP)
    ) u_dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .i_pipeline_ready (i_pipeline_ready),
        .o_valid          (o_valid),
        .o_pc             (o_pc),
        .o_instruction    (o_instruction),
        .o_req_valid      (o_req_valid),
        .o_req_addr       (o_req_addr),
        .i_req_ready      (i_req_ready),
        .i_rsp_valid      (i_rsp_valid),
        .i_rsp_data       (i_rsp_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ------------------------------------------------------------------------
    // Bench state
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } creq_t;

    creq_t       icq[$];          // accepted icache requests, in order
    int          n_cmp;
    int          n_err;
    int          cyc;
    int          lat;
    int          pops;
    logic [31:0] exp_out_pc;      // PC the consumer must receive next
    logic [31:0] exp_req;         // address the next accepted request must carry
    logic        prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic        post_redirect;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_inputs(input logic rst, input logic redir, input logic [31:0] rpc,
                              input logic pready, input logic rready, input logic rsp_ok);
        i_reset          = rst;
        i_redirect       = redir;
        i_redirect_pc    = rpc;
        i_pipeline_ready = pready;
        i_req_ready      = rready;
        if (!rst && rsp_ok && icq.size() > 0 && icq[0].due <= cyc) begin
            i_rsp_valid = 1'b1;
            i_rsp_data  = mem_word(icq[0].addr);
        end else begin
            i_rsp_valid = 1'b0;
            i_rsp_data  = $urandom;
        end
    endtask

    // Let combinational outputs settle, check them against the stream model,
    // then account for this cycle's handshakes.
    task automatic settle_and_model();
        #1;
        if (i_reset) begin
            icq.delete();
            exp_out_pc    = RESET_VECTOR;
            exp_req       = RESET_VECTOR;
            prev_hold     = 1'b0;
            post_redirect = 1'b0;
            return;
        end
        if (!o_valid) begin
            chk("idle_pc", o_pc, 32'h0);
            chk("idle_instr", o_instruction, NOOP);
        end
        if (post_redirect) chk("flush_valid", 32'(o_valid), 32'h0);
        if (prev_hold) begin
            chk("hold_valid", 32'(o_valid), 32'h1);
            chk("hold_pc", o_pc, prev_pc);
            chk("hold_instr", o_instruction, prev_instr);
        end
        if (i_redirect) chk("redir_noreq", 32'(o_req_valid), 32'h0);
        if (i_rsp_valid) void'(icq.pop_front());
        if (o_req_valid && i_req_ready) begin
            chk("req_addr", o_req_addr, exp_req);
            icq.push_back('{addr: exp_req, due: cyc + lat});
            exp_req = exp_req + 32'd4;
            chk("outstanding_le_max", 32'(icq.size() <= MAX_OUT), 32'h1);
        end
        if (o_valid && i_pipeline_ready && !i_redirect) begin
            chk("out_pc", o_pc, exp_out_pc);
            chk("out_instr", o_instruction, mem_word(exp_out_pc));
            exp_out_pc = exp_out_pc + 32'd4;
            pops++;
        end
        prev_hold     = o_valid && !i_pipeline_ready && !i_redirect;
        prev_pc       = o_pc;
        prev_instr    = o_instruction;
        post_redirect = i_redirect;
        if (i_redirect) begin
            exp_out_pc = i_redirect_pc & ~32'd3;
            exp_req    = i_redirect_pc & ~32'd3;
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic cycle(input logic rst, input logic redir, input logic [31:0] rpc,
                         input logic pready, input logic rready, input logic rsp_ok);
        set_inputs(rst, redir, rpc, pready, rready, rsp_ok);
        settle_and_model();
        next_cycle();
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table (icache latency 1, always ready)
    // ------------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        pready;
        logic        chk_en;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_reqv;
        logic [31:0] exp_addr;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic pready, input logic chk_en, input logic ev,
                                input logic [31:0] epc, input logic erv, input logic [31:0] ea);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.pready = pready; v.chk_en = chk_en;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_reqv = erv; v.exp_addr = ea;
        return v;
    endfunction

    vec_t tbl[24];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        int   p0;

        n_cmp = 0; n_err = 0; cyc = 0; lat = 1; pops = 0;
        exp_out_pc = RESET_VECTOR; exp_req = RESET_VECTOR;
        prev_hold = 1'b0; prev_pc = '0; prev_instr = '0; post_redirect = 1'b0;
        i_reset = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0; i_pipeline_ready = 1'b0;
        i_req_ready = 1'b0; i_rsp_valid = 1'b0; i_rsp_data = '0;

        //            rst  rdr  rpc         rdy  chk  valid pc          reqv addr
        tbl[0]  = mk(1'b1, 1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0);
        tbl[1]  = mk(1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0);
        tbl[2]  = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 32'h0);
        tbl[3]  = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 32'h4);
        tbl[4]  = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h0,     1'b1, 32'h8);
        tbl[5]  = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h4,     1'b1, 32'hC);
        tbl[6]  = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h8,     1'b1, 32'h10);
        tbl[7]  = mk(1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'hC,     1'b1, 32'h14);
        tbl[8]  = mk(1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'hC,     1'b1, 32'h18);
        tbl[9]  = mk(1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'hC,     1'b0, 32'h0);
        tbl[10] = mk(1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'hC,     1'b0, 32'h0);
        tbl[11] = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'hC,     1'b0, 32'h0);
        tbl[12] = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h10,    1'b1, 32'h1C);
        tbl[13] = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h14,    1'b1, 32'h20);
        tbl[14] = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h18,    1'b1, 32'h24);
        tbl[15] = mk(1'b0, 1'b1, 32'h100,   1'b1, 1'b1, 1'b1, 32'h1C,    1'b0, 32'h0);
        tbl[16] = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 32'h100);
        tbl[17] = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 32'h104);
        tbl[18] = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h100,   1'b1, 32'h108);
        tbl[19] = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h104,   1'b1, 32'h10C);
        tbl[20] = mk(1'b0, 1'b1, 32'h202,   1'b1, 1'b1, 1'b1, 32'h108,   1'b0, 32'h0);
        tbl[21] = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 32'h200);
        tbl[22] = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 32'h204);
        tbl[23] = mk(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h200,   1'b1, 32'h208);

        @(posedge i_clk);
        #1;

        // ---- table phase: streaming, stall/fill/drain, two redirects ----
        for (int i = 0; i < 24; i++) begin
            set_inputs(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].pready, 1'b1, 1'b1);
            settle_and_model();
            if (tbl[i].chk_en) begin
                chk("tv_valid", 32'(o_valid), 32'(tbl[i].exp_valid));
                chk("tv_pc", o_pc, tbl[i].exp_pc);
                chk("tv_instr", o_instruction,
                    tbl[i].exp_valid ? mem_word(tbl[i].exp_pc) : NOOP);
                chk("tv_req_valid", 32'(o_req_valid), 32'(tbl[i].exp_reqv));
                if (tbl[i].exp_reqv) chk("tv_req_addr", o_req_addr, tbl[i].exp_addr);
            end
            next_cycle();
        end

        // ---- redirect with two requests in flight (latency 2) ----
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        lat = 2;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (icq.size() == 2) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        end
        if (!found) begin
            n_cmp++; n_err++;
            $display("FAIL two_inflight: timeout waiting for 2 outstanding requests");
        end
        set_inputs(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
        settle_and_model();
        next_cycle();
        found = 1'b0;
        for (int k = 0; k < 12; k++) begin
            set_inputs(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            settle_and_model();
            if (o_valid) begin
                found = 1'b1;
                chk("redir_first_pc", o_pc, 32'h100);
                chk("redir_first_instr", o_instruction, mem_word(32'h100));
                next_cycle();
                break;
            end
            next_cycle();
        end
        if (!found) begin
            n_cmp++; n_err++;
            $display("FAIL redir_refill: o_valid got 0 expected 1 within 12 cycles");
        end

        // ---- req_ready toggling, latency 3 ----
        lat = 3;
        p0 = pops;
        for (int k = 0; k < 40; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, (k % 2) == 0, 1'b1);
        end
        chk("toggle_progress", 32'(pops - p0 >= 10), 32'h1);

        // ---- fill FIFO, then reset mid-stream ----
        lat = 1;
        for (int k = 0; k < 12; k++) begin
            set_inputs(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            settle_and_model();
            if (k == 11) begin
                chk("full_valid", 32'(o_valid), 32'h1);
                chk("full_no_req", 32'(o_req_valid), 32'h0);
            end
            next_cycle();
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        set_inputs(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        settle_and_model();
        chk("post_rst_valid", 32'(o_valid), 32'h0);
        chk("post_rst_instr", o_instruction, NOOP);
        chk("post_rst_req_valid", 32'(o_req_valid), 32'h1);
        chk("post_rst_req_addr", o_req_addr, RESET_VECTOR);
        next_cycle();

        // ---- randomized traffic against the stream model ----
        for (int k = 0; k < 800; k++) begin
            if (k % 100 == 0) lat = $urandom_range(1, 4);
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 31) == 0,
                  $urandom,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 4) != 0);
        end

        // ---- steady-state drain: near one instruction per cycle ----
        lat = 1;
        p0 = pops;
        for (int k = 0; k < 24; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        end
        chk("steady_throughput", 32'(pops - p0 >= 16), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
